// File: rtl/ddr4_mem_tester.sv
// rtl/ddr4_mem_tester.sv - Avalon-MM write/readback pattern tester for the DDR4-C EMIF
module ddr4_mem_tester #(
  parameter int          ADDR_WIDTH      = 27,
  parameter int          DATA_WIDTH      = 512,
  parameter int          NUM_WORDS       = 1024,
  parameter int          MAX_OUTSTANDING = 32,
  parameter logic [31:0] SEED            = 32'hA5A5_0000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cal_success,
  input  logic                      cal_fail,
  input  logic                      start,
  output logic [ADDR_WIDTH-1:0]     amm_address,
  output logic                      amm_read,
  output logic                      amm_write,
  output logic [DATA_WIDTH-1:0]     amm_writedata,
  output logic [DATA_WIDTH/8-1:0]   amm_byteenable,
  output logic [6:0]                amm_burstcount,
  input  logic                      amm_waitrequest,
  input  logic [DATA_WIDTH-1:0]     amm_readdata,
  input  logic                      amm_readdatavalid,
  output logic                      done,
  output logic                      pass,
  output logic [15:0]               err_count,
  output logic [ADDR_WIDTH-1:0]     first_err_addr,
  output logic [3:0]                led
);

  localparam int                  LANES   = DATA_WIDTH / 32;
  // Counters are one bit wider than the address so they can hold NUM_WORDS itself.
  localparam logic [ADDR_WIDTH:0] LP_NUM  = (ADDR_WIDTH+1)'(NUM_WORDS);
  localparam logic [ADDR_WIDTH:0] LP_LAST = (ADDR_WIDTH+1)'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH:0] LP_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [7:0]          LP_MAX  = 8'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_PASS,
    ST_FAIL
  } state_t;

  // Address-derived word: lane i = ((addr << 4) + i) ^ SEED, lane 0 in the low bits.
  function automatic logic [DATA_WIDTH-1:0] f_pattern(input logic [ADDR_WIDTH-1:0] i_addr);
    logic [31:0]           base;
    logic [DATA_WIDTH-1:0] word;
    base = 32'(i_addr) << 4;
    word = '0;
    for (int i = 0; i < LANES; i++) begin
      word[i*32 +: 32] = (base + 32'(i)) ^ SEED;
    end
    return word;
  endfunction

  state_t                r_state;
  logic [ADDR_WIDTH:0]   r_wr_addr;
  logic [ADDR_WIDTH:0]   r_rd_addr;
  logic [ADDR_WIDTH:0]   r_cmp_addr;
  logic [7:0]            r_outstanding;
  logic [15:0]           r_err_count;
  logic [ADDR_WIDTH-1:0] r_first_err;
  logic [ADDR_WIDTH-1:0] r_amm_address;
  logic                  r_amm_read;
  logic                  r_amm_write;
  logic [DATA_WIDTH-1:0] r_amm_wdata;
  logic                  r_done;
  logic                  r_pass;
  logic [2:0]            r_led_hi;
  logic                  r_cal_q;

  state_t                w_state_n;
  logic [ADDR_WIDTH:0]   w_wr_addr_n;
  logic [ADDR_WIDTH:0]   w_rd_addr_n;
  logic [ADDR_WIDTH:0]   w_cmp_addr_n;
  logic [7:0]            w_out_n;
  logic [15:0]           w_err_n;
  logic [ADDR_WIDTH-1:0] w_first_n;
  logic [ADDR_WIDTH-1:0] w_addr_n;
  logic                  w_read_n;
  logic                  w_write_n;
  logic [DATA_WIDTH-1:0] w_wdata_n;
  logic                  w_start_run;
  logic                  w_finish;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_rsp;
  logic                  w_rsp_dec;
  logic [DATA_WIDTH-1:0] w_exp_data;
  logic                  w_mismatch;

  assign w_wr_acc   = r_amm_write & ~amm_waitrequest;
  assign w_rd_acc   = r_amm_read & ~amm_waitrequest;
  // Responses only count while a readback is in progress; stray strobes in PASS/FAIL are ignored.
  assign w_rsp      = amm_readdatavalid & ((r_state == ST_READ) | (r_state == ST_DRAIN));
  assign w_rsp_dec  = w_rsp & (r_outstanding != 8'd0);
  assign w_exp_data = f_pattern(r_cmp_addr[ADDR_WIDTH-1:0]);
  assign w_mismatch = w_rsp & (amm_readdata != w_exp_data);

  // Next-state and next-value logic for the sequencer, counters and Avalon command.
  always_comb begin
    w_state_n    = r_state;
    w_wr_addr_n  = r_wr_addr;
    w_rd_addr_n  = r_rd_addr;
    w_cmp_addr_n = r_cmp_addr;
    w_out_n      = r_outstanding;
    w_err_n      = r_err_count;
    w_first_n    = r_first_err;
    w_addr_n     = r_amm_address;
    w_read_n     = r_amm_read;
    w_write_n    = r_amm_write;
    w_wdata_n    = r_amm_wdata;
    w_start_run  = 1'b0;
    w_finish     = 1'b0;

    if (w_rd_acc) begin
      w_rd_addr_n = r_rd_addr + LP_ONE;
    end

    if (w_rd_acc && !w_rsp_dec) begin
      w_out_n = r_outstanding + 8'd1;
    end else if (!w_rd_acc && w_rsp_dec) begin
      w_out_n = r_outstanding - 8'd1;
    end

    if (w_rsp) begin
      w_cmp_addr_n = r_cmp_addr + LP_ONE;
      if (w_mismatch) begin
        if (r_err_count != 16'hFFFF) begin
          w_err_n = r_err_count + 16'd1;
        end
        if (r_err_count == 16'd0) begin
          w_first_n = r_cmp_addr[ADDR_WIDTH-1:0];
        end
      end
    end

    w_finish = (w_rd_addr_n == LP_NUM) && (w_out_n == 8'd0) && (w_cmp_addr_n == LP_NUM);

    case (r_state)
      ST_IDLE: begin
        if (cal_fail) begin
          w_state_n = ST_FAIL;
        end else if (cal_success) begin
          w_start_run = 1'b1;
        end
      end
      ST_WRITE: begin
        if (w_wr_acc) begin
          if (r_wr_addr == LP_LAST) begin
            w_state_n = ST_READ;
            w_write_n = 1'b0;
            w_read_n  = 1'b1;
            w_addr_n  = '0;
          end else begin
            w_wr_addr_n = r_wr_addr + LP_ONE;
            w_addr_n    = w_wr_addr_n[ADDR_WIDTH-1:0];
            w_wdata_n   = f_pattern(w_wr_addr_n[ADDR_WIDTH-1:0]);
          end
        end
      end
      ST_READ, ST_DRAIN: begin
        // A stalled read holds its command; otherwise issue the next one if the window allows.
        if ((r_state == ST_READ) && !(r_amm_read && amm_waitrequest)) begin
          w_read_n = (w_rd_addr_n < LP_NUM) && (w_out_n < LP_MAX);
          w_addr_n = w_rd_addr_n[ADDR_WIDTH-1:0];
        end
        if ((r_state == ST_READ) && (w_rd_addr_n == LP_NUM)) begin
          w_state_n = ST_DRAIN;
        end
        if (w_finish) begin
          w_read_n  = 1'b0;
          w_state_n = (w_err_n == 16'd0) ? ST_PASS : ST_FAIL;
        end
      end
      ST_PASS, ST_FAIL: begin
        if (start) begin
          w_start_run = 1'b1;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase

    if (w_start_run) begin
      w_state_n    = ST_WRITE;
      w_wr_addr_n  = '0;
      w_rd_addr_n  = '0;
      w_cmp_addr_n = '0;
      w_out_n      = 8'd0;
      w_err_n      = 16'd0;
      w_first_n    = '0;
      w_write_n    = 1'b1;
      w_read_n     = 1'b0;
      w_addr_n     = '0;
      w_wdata_n    = f_pattern('0);
    end
  end

  // State, counter and output registers; status flags are derived from the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_wr_addr     <= '0;
      r_rd_addr     <= '0;
      r_cmp_addr    <= '0;
      r_outstanding <= 8'd0;
      r_err_count   <= 16'd0;
      r_first_err   <= '0;
      r_amm_address <= '0;
      r_amm_read    <= 1'b0;
      r_amm_write   <= 1'b0;
      r_amm_wdata   <= '0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_led_hi      <= 3'b000;
      r_cal_q       <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_wr_addr     <= w_wr_addr_n;
      r_rd_addr     <= w_rd_addr_n;
      r_cmp_addr    <= w_cmp_addr_n;
      r_outstanding <= w_out_n;
      r_err_count   <= w_err_n;
      r_first_err   <= w_first_n;
      r_amm_address <= w_addr_n;
      r_amm_read    <= w_read_n;
      r_amm_write   <= w_write_n;
      r_amm_wdata   <= w_wdata_n;
      r_done        <= (w_state_n == ST_PASS) || (w_state_n == ST_FAIL);
      r_pass        <= (w_state_n == ST_PASS);
      r_led_hi      <= {(w_state_n == ST_FAIL), (w_state_n == ST_PASS),
                        (w_state_n == ST_WRITE) || (w_state_n == ST_READ) || (w_state_n == ST_DRAIN)};
      r_cal_q       <= cal_success;
    end
  end

  assign amm_address    = r_amm_address;
  assign amm_read       = r_amm_read;
  assign amm_write      = r_amm_write;
  assign amm_writedata  = r_amm_wdata;
  assign amm_byteenable = '1;
  assign amm_burstcount = 7'd1;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err_count;
  assign first_err_addr = r_first_err;
  assign led            = {r_led_hi, r_cal_q};

endmodule

// File: tb/tb_ddr4_mem_tester.sv
// tb/tb_ddr4_mem_tester.sv - directed self-checking bench for ddr4_mem_tester
module tb_ddr4_mem_tester;

  localparam int AW = 8;
  localparam int DW = 64;
  localparam int NW = 16;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cal_success = 1'b0;
  logic          cal_fail = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] amm_address;
  logic          amm_read;
  logic          amm_write;
  logic [DW-1:0] amm_writedata;
  logic [DW/8-1:0] amm_byteenable;
  logic [6:0]    amm_burstcount;
  logic          amm_waitrequest = 1'b0;
  logic [DW-1:0] amm_readdata = '0;
  logic          amm_readdatavalid = 1'b0;
  logic          done;
  logic          pass;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;
  logic [3:0]    led;

  ddr4_mem_tester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .MAX_OUTSTANDING(MO), .SEED(32'hA5A5_0000)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cal_success(cal_success), .cal_fail(cal_fail), .start(start),
    .amm_address(amm_address), .amm_read(amm_read), .amm_write(amm_write),
    .amm_writedata(amm_writedata), .amm_byteenable(amm_byteenable), .amm_burstcount(amm_burstcount),
    .amm_waitrequest(amm_waitrequest), .amm_readdata(amm_readdata),
    .amm_readdatavalid(amm_readdatavalid), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .led(led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err = 0;

  // Behavioural memory / monitor knobs and statistics.
  int  lat = 5;
  bit  wait_rand = 1'b0;
  bit  corrupt = 1'b0;
  logic [DW-1:0] mem [0:NW-1];
  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } rsp_t;
  rsp_t q[$];
  int wr_cnt = 0, rd_cnt = 0, inflight = 0, max_inflight = 0, same_cyc = 0, stall_cnt = 0;
  int stab_viol = 0, order_viol = 0, data_viol = 0, out_mism = 0;
  int first_wr_cyc = 0, last_wr_cyc = 0, last_rsp_cyc = 0, exp_wr = 0, exp_rd = 0;
  bit acc_w, acc_r, prev_stall = 1'b0, p_wlvl = 1'b0;
  logic p_w = 1'b0, p_r = 1'b0;
  logic [AW-1:0] p_a = '0;
  logic [DW-1:0] p_d = '0;
  logic [DW-1:0] rd_word;

  function automatic logic [DW-1:0] model_word(input int a);
    logic [31:0] base;
    logic [DW-1:0] w;
    base = a;
    base = base << 4;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = (base + i) ^ 32'hA5A5_0000;
    return w;
  endfunction

  // Memory responder and protocol monitor, acting on the falling edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      inflight = 0;
      prev_stall = 1'b0;
      p_wlvl = 1'b0;
      amm_waitrequest = 1'b0;
      amm_readdatavalid = 1'b0;
      exp_wr = 0;
      exp_rd = 0;
    end else begin
      if (dut.r_outstanding !== 8'(inflight)) out_mism++;
      if (prev_stall && (amm_write !== p_w || amm_read !== p_r || amm_address !== p_a || amm_writedata !== p_d))
        stab_viol++;
      if (amm_write && !p_wlvl) begin
        exp_wr = 0;
        max_inflight = 0;
      end
      amm_waitrequest = wait_rand ? 1'($urandom_range(0, 1)) : 1'b0;
      acc_w = amm_write && !amm_waitrequest;
      acc_r = amm_read && !amm_waitrequest;
      if (acc_w) begin
        if (amm_address !== 8'(exp_wr)) order_viol++;
        if (amm_writedata !== model_word(int'(amm_address))) data_viol++;
        mem[amm_address[3:0]] = amm_writedata;
        if (amm_address == 8'd0) first_wr_cyc = cyc;
        if (amm_address == 8'(NW-1)) last_wr_cyc = cyc;
        exp_wr++;
        exp_rd = 0;
        wr_cnt++;
      end
      if (acc_r) begin
        if (amm_address !== 8'(exp_rd)) order_viol++;
        rd_word = mem[amm_address[3:0]];
        if (corrupt && (amm_address == 8'd5 || amm_address == 8'd9)) rd_word[0] = ~rd_word[0];
        q.push_back('{d: rd_word, due: cyc + lat});
        exp_rd++;
        rd_cnt++;
        inflight++;
      end
      if (q.size() > 0 && q[0].due <= cyc) begin
        amm_readdata = q[0].d;
        amm_readdatavalid = 1'b1;
        q.pop_front();
        inflight--;
        last_rsp_cyc = cyc;
        if (acc_r) same_cyc++;
      end else begin
        amm_readdatavalid = 1'b0;
      end
      if (inflight > max_inflight) max_inflight = inflight;
      if (amm_waitrequest && (amm_write || amm_read)) stall_cnt++;
      prev_stall = amm_waitrequest && (amm_write || amm_read);
      p_w = amm_write;
      p_r = amm_read;
      p_a = amm_address;
      p_d = amm_writedata;
      p_wlvl = amm_write;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, output int seen);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    seen = cyc;
    n_checks++;
    assert (done === 1'b1) else begin
      n_err++;
      $error("FAIL %s: done observed=%0b expected=1 within budget", tag, done);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int s_wr, s_rd, s_stab, s_ord, s_data, s_out, s_same, s_stall, base, seen;

  task automatic snap();
    s_wr = wr_cnt; s_rd = rd_cnt; s_stab = stab_viol; s_ord = order_viol;
    s_data = data_viol; s_out = out_mism; s_same = same_cyc; s_stall = stall_cnt;
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_write", 64'(amm_write), 64'd0);
    check("rst_read", 64'(amm_read), 64'd0);
    check("rst_addr", 64'(amm_address), 64'd0);
    check("rst_wdata", 64'(amm_writedata), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_err", 64'(err_count), 64'd0);
    check("rst_first", 64'(first_err_addr), 64'd0);
    check("rst_led", 64'(led), 64'd0);
    check("byteenable", 64'(amm_byteenable), 64'hFF);
    check("burstcount", 64'(amm_burstcount), 64'd1);

    // Clean run: calibration after ten cycles
    @(negedge clk);
    reset_n = 1'b1;
    repeat (9) @(negedge clk);
    snap();
    base = cyc;
    cal_success = 1'b1;
    wait_done("clean_done", seen);
    check("clean_pass", 64'(pass), 64'd1);
    check("clean_err", 64'(err_count), 64'd0);
    check("clean_writes", 64'(wr_cnt - s_wr), 64'd16);
    check("clean_reads", 64'(rd_cnt - s_rd), 64'd16);
    check("clean_first_wr_cyc", 64'(first_wr_cyc - base), 64'd1);
    check("clean_last_wr_cyc", 64'(last_wr_cyc - base), 64'd16);
    check("word3_lane1", 64'(mem[3][63:32]), 64'hA5A5_0031);
    check("word0_lane0", 64'(mem[0][31:0]), 64'hA5A5_0000);
    check("word15_lane1", 64'(mem[15][63:32]), 64'hA5A5_00F1);
    check("clean_data", 64'(data_viol - s_data), 64'd0);
    check("clean_order", 64'(order_viol - s_ord), 64'd0);
    check("done_latency", 64'(seen - last_rsp_cyc), 64'd1);
    check("clean_led", 64'(led), 64'b0101);
    check("clean_max_inflight", 64'(max_inflight <= MO), 64'd1);
    check("clean_idle_cmds", 64'({amm_write, amm_read}), 64'd0);

    // Backpressure: random waitrequest
    snap();
    wait_rand = 1'b1;
    pulse_start();
    wait_done("bp_done", seen);
    wait_rand = 1'b0;
    check("bp_pass", 64'(pass), 64'd1);
    check("bp_writes", 64'(wr_cnt - s_wr), 64'd16);
    check("bp_reads", 64'(rd_cnt - s_rd), 64'd16);
    check("bp_stable", 64'(stab_viol - s_stab), 64'd0);
    check("bp_order", 64'(order_viol - s_ord), 64'd0);
    check("bp_stalls_seen", 64'(stall_cnt > s_stall), 64'd1);
    check("bp_outstanding_track", 64'(out_mism - s_out), 64'd0);

    // Outstanding limit with long read latency
    snap();
    lat = 20;
    pulse_start();
    wait_done("lim_done", seen);
    lat = 5;
    check("lim_pass", 64'(pass), 64'd1);
    check("lim_max_inflight", 64'(max_inflight), 64'd4);
    check("lim_outstanding_track", 64'(out_mism - s_out), 64'd0);
    check("lim_same_cycle_seen", 64'(same_cyc > s_same), 64'd1);
    check("lim_reads", 64'(rd_cnt - s_rd), 64'd16);

    // Corruption at addresses 5 and 9
    corrupt = 1'b1;
    pulse_start();
    wait_done("cor_done", seen);
    corrupt = 1'b0;
    check("cor_pass", 64'(pass), 64'd0);
    check("cor_err", 64'(err_count), 64'd2);
    check("cor_first", 64'(first_err_addr), 64'd5);
    check("cor_led", 64'(led), 64'b1001);

    // Restart from FAIL with memory fixed
    pulse_start();
    check("rs_cleared_err", 64'(err_count), 64'd0);
    check("rs_busy_led", 64'(led), 64'b0011);
    wait_done("rs_done", seen);
    check("rs_pass", 64'(pass), 64'd1);
    check("rs_err", 64'(err_count), 64'd0);
    check("rs_first", 64'(first_err_addr), 64'd0);

    // Reset pulse mid-WRITE
    pulse_start();
    repeat (3) @(negedge clk);
    check("mid_write_active", 64'(amm_write), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mr_write", 64'(amm_write), 64'd0);
    check("mr_read", 64'(amm_read), 64'd0);
    check("mr_addr", 64'(amm_address), 64'd0);
    check("mr_wdata", 64'(amm_writedata), 64'd0);
    check("mr_done", 64'(done), 64'd0);
    check("mr_led", 64'(led), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    snap();
    wait_done("mr_rerun_done", seen);
    check("mr_rerun_pass", 64'(pass), 64'd1);
    check("mr_rerun_writes", 64'(wr_cnt - s_wr), 64'd16);
    check("mr_rerun_order", 64'(order_viol - s_ord), 64'd0);

    // Calibration failure
    @(negedge clk);
    reset_n = 1'b0;
    cal_success = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("cf_idle_done", 64'(done), 64'd0);
    snap();
    cal_fail = 1'b1;
    @(negedge clk);
    check("cf_done", 64'(done), 64'd1);
    check("cf_pass", 64'(pass), 64'd0);
    check("cf_err", 64'(err_count), 64'd0);
    check("cf_led", 64'(led), 64'b1000);
    repeat (20) @(negedge clk);
    check("cf_no_cmds", 64'((wr_cnt - s_wr) + (rd_cnt - s_rd)), 64'd0);
    check("cf_write_low", 64'(amm_write), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
